adder_window_accum: RTL

- Downstream consumer of the adder stage.
- Takes the 13-bit result {c_out, sum} each valid cycle and accumulates it over a fixed window of WIN_LEN accepted samples.
- Also tracks the window maximum.
- Publishes registered results with a single-cycle done pulse, so the bench compares one windowed value per window against the Matlab model instead of every cycle.

---
 rtl/adder_window_accum.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/adder_window_accum.sv
// Windowed accumulator/max tracker for the adder stage result {c_out, sum}.
// Optional signature register enabled by macro ADDER_ACCUM_SIG_EN.
module adder_window_accum #(
  parameter int DATA_W  = 12,
  parameter int WIN_LEN = 100,
  parameter int ACC_W   = 20,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_cout,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc_out,
  output logic [DATA_W:0]   max_out,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [15:0]       sig_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic               busy_r;
  logic               done_r;
  logic [ACC_W-1:0]   acc_r;
  logic [DATA_W:0]    max_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [ACC_W-1:0]   acc_out_r;
  logic [DATA_W:0]    max_out_r;

  logic [DATA_W:0]    sample_s;
  logic               accept_s;
  logic               last_s;
  logic               clear_s;
  logic [ACC_W-1:0]   acc_nx_s;
  logic [DATA_W:0]    max_nx_s;

  assign sample_s = {in_cout, in_sum};
  assign accept_s = (state_r == ACCUM) && in_valid;
  assign last_s   = accept_s && (cnt_r == CNT_W'(WIN_LEN - 1));
  assign clear_s  = (state_r == IDLE) && start;

  // Running sum and maximum including the sample offered this cycle
  always_comb begin
    acc_nx_s = acc_r + {{(ACC_W-DATA_W-1){1'b0}}, sample_s};
    if (sample_s > max_r) begin
      max_nx_s = sample_s;
    end else begin
      max_nx_s = max_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = ACCUM;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACCUM: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = ACCUM;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == ACCUM);
      done_r  <= (state_nx_s == DONE);
    end
  end

  // Window datapath; published results only move on window completion
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_r     <= {ACC_W{1'b0}};
      max_r     <= {(DATA_W+1){1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      acc_out_r <= {ACC_W{1'b0}};
      max_out_r <= {(DATA_W+1){1'b0}};
    end else if (clear_s) begin
      acc_r <= {ACC_W{1'b0}};
      max_r <= {(DATA_W+1){1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      acc_r <= acc_nx_s;
      max_r <= max_nx_s;
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (last_s) begin
        acc_out_r <= acc_nx_s;
        max_out_r <= max_nx_s;
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign acc_out    = acc_out_r;
  assign max_out    = max_out_r;
  assign sample_cnt = cnt_r;

`ifdef ADDER_ACCUM_SIG_EN
  logic [15:0] sig_r;
  logic [15:0] sig_out_r;

  function automatic logic [15:0] sig_step(input logic [15:0] sig, input logic [DATA_W:0] s);
    return {sig[14:0], sig[15]} ^ 16'(s);
  endfunction

  // Signature accumulates alongside the sum and publishes with it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sig_r     <= 16'h0000;
      sig_out_r <= 16'h0000;
    end else if (clear_s) begin
      sig_r <= 16'h0000;
    end else if (accept_s) begin
      sig_r <= sig_step(sig_r, sample_s);
      if (last_s) begin
        sig_out_r <= sig_step(sig_r, sample_s);
      end
    end
  end

  assign sig_out = sig_out_r;
`else
  assign sig_out = 16'h0000;
`endif

endmodule
